// File: rtl/sync_fifo_p.sv
// rtl/sync_fifo_p.sv - parametrised synchronous FIFO with flush, thresholds and sticky error flags
module sync_fifo_p #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_rd_valid,
  input  logic              i_flush,
  input  logic              i_clr_err,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_almost_empty,
  output logic              o_almost_full,
  output logic [CW-1:0]     o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_data_out;
  logic              r_rd_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic w_empty;
  logic w_full;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_wr_rej;
  logic w_rd_rej;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  // A read frees a slot in the same cycle, so a full FIFO still takes rd+wr together.
  assign w_rd_acc = i_rd && !w_empty;
  assign w_wr_acc = i_wr && (!w_full || w_rd_acc);
  assign w_wr_rej = i_wr && !w_wr_acc;
  assign w_rd_rej = i_rd && !w_rd_acc;

  always_ff @(posedge i_clk) begin
    if (!i_flush && w_wr_acc) begin
      r_mem[r_wptr] <= i_data_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= r_overflow && !i_clr_err;
      r_underflow <= r_underflow && !i_clr_err;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rptr     <= r_rptr + 1'b1;
        r_data_out <= r_mem[r_rptr];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A fresh rejection wins over a simultaneous clear.
      r_overflow  <= w_wr_rej || (r_overflow && !i_clr_err);
      r_underflow <= w_rd_rej || (r_underflow && !i_clr_err);
    end
  end

  assign o_data_out     = r_data_out;
  assign o_rd_valid     = r_rd_valid;
  assign o_count        = r_count;
  assign o_empty        = w_empty;
  assign o_full         = w_full;
  assign o_almost_empty = (r_count <= CW'(AE_LEVEL));
  assign o_almost_full  = (r_count >= CW'(AF_LEVEL));
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule
